// File: rtl/ysyx_23060170_shift_arb.sv
// rtl/ysyx_23060170_shift_arb.sv - round-robin arbiter sharing one 32-bit shifter between two requesters
module ysyx_23060170_shift_arb (
  input  logic        clock,
  input  logic        reset,
  input  logic        flush,
  input  logic        req0_valid,
  output logic        req0_ready,
  input  logic [31:0] req0_src,
  input  logic [4:0]  req0_amt,
  input  logic [2:0]  req0_op,
  input  logic        req1_valid,
  output logic        req1_ready,
  input  logic [31:0] req1_src,
  input  logic [4:0]  req1_amt,
  input  logic [2:0]  req1_op,
  output logic        rsp0_valid,
  input  logic        rsp0_ready,
  output logic        rsp1_valid,
  input  logic        rsp1_ready,
  output logic [31:0] rsp_data,
  output logic        rsp_err
);

  typedef enum logic [1:0] {S_IDLE, S_EXEC, S_RESP} state_e;

  state_e      state_q, state_d;
  // Port that won the last accepted request; reset to 1 so port 0 is favoured first.
  logic        last_gnt_q, last_gnt_d;
  logic [31:0] src_q;
  logic [4:0]  amt_q;
  logic [2:0]  op_q;
  logic        owner_q;
  logic [31:0] data_q;
  logic        err_q;

  logic        gnt0, gnt1, can_accept, accept, rsp_hs;
  logic [31:0] shift_res;
  logic        op_onehot;

  assign gnt1       = req1_valid & (~req0_valid | ~last_gnt_q);
  assign gnt0       = req0_valid & ~gnt1;
  assign can_accept = (state_q == S_IDLE) & ~flush & ~reset;
  assign req0_ready = can_accept & gnt0;
  assign req1_ready = can_accept & gnt1;
  assign accept     = req0_ready | req1_ready;

  // Valid is masked during flush/reset so no handshake can complete on a discarded result.
  assign rsp0_valid = (state_q == S_RESP) & ~owner_q & ~flush & ~reset;
  assign rsp1_valid = (state_q == S_RESP) &  owner_q & ~flush & ~reset;
  assign rsp_hs     = rsp0_valid & rsp0_ready | rsp1_valid & rsp1_ready;
  assign rsp_data   = data_q;
  assign rsp_err    = err_q;

  assign op_onehot = (op_q == 3'b100) | (op_q == 3'b010) | (op_q == 3'b001);

  always_comb begin
    shift_res = 32'h0;
    unique case (op_q)
      3'b100:  shift_res = src_q << amt_q;
      3'b010:  shift_res = src_q >> amt_q;
      3'b001:  shift_res = $unsigned($signed(src_q) >>> amt_q);
      default: shift_res = 32'h0;
    endcase
  end

  always_comb begin
    state_d    = state_q;
    last_gnt_d = last_gnt_q;
    unique case (state_q)
      S_IDLE: begin
        if (accept) begin
          state_d    = S_EXEC;
          last_gnt_d = gnt1;
        end
      end
      S_EXEC:  state_d = S_RESP;
      S_RESP:  if (rsp_hs) state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
    if (flush) state_d = S_IDLE;
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state_q    <= S_IDLE;
      last_gnt_q <= 1'b1;
      src_q      <= 32'h0;
      amt_q      <= 5'h0;
      op_q       <= 3'h0;
      owner_q    <= 1'b0;
      data_q     <= 32'h0;
      err_q      <= 1'b0;
    end else begin
      state_q    <= state_d;
      last_gnt_q <= last_gnt_d;
      if (accept) begin
        src_q   <= gnt1 ? req1_src : req0_src;
        amt_q   <= gnt1 ? req1_amt : req0_amt;
        op_q    <= gnt1 ? req1_op  : req0_op;
        owner_q <= gnt1;
      end
      if (state_q == S_EXEC && !flush) begin
        data_q <= shift_res;
        err_q  <= ~op_onehot;
      end
    end
  end

endmodule

// File: tb/tb_ysyx_23060170_shift_arb.sv
// tb/tb_ysyx_23060170_shift_arb.sv - directed self-checking bench for the shared shifter arbiter
module tb_ysyx_23060170_shift_arb;

  logic        clock = 1'b0;
  logic        reset, flush;
  logic        req0_valid, req0_ready, req1_valid, req1_ready;
  logic [31:0] req0_src, req1_src;
  logic [4:0]  req0_amt, req1_amt;
  logic [2:0]  req0_op, req1_op;
  logic        rsp0_valid, rsp0_ready, rsp1_valid, rsp1_ready;
  logic [31:0] rsp_data;
  logic        rsp_err;

  int passed = 0;
  int failed = 0;
  int total  = 0;

  ysyx_23060170_shift_arb dut (
    .clock(clock), .reset(reset), .flush(flush),
    .req0_valid(req0_valid), .req0_ready(req0_ready), .req0_src(req0_src),
    .req0_amt(req0_amt), .req0_op(req0_op),
    .req1_valid(req1_valid), .req1_ready(req1_ready), .req1_src(req1_src),
    .req1_amt(req1_amt), .req1_op(req1_op),
    .rsp0_valid(rsp0_valid), .rsp0_ready(rsp0_ready),
    .rsp1_valid(rsp1_valid), .rsp1_ready(rsp1_ready),
    .rsp_data(rsp_data), .rsp_err(rsp_err)
  );

  always #5 clock = ~clock;

  initial begin
    #200000;
    $display("FAIL watchdog: observed timeout expected completion");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) passed++;
    else begin
      failed++;
      $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic set_req(input int port, input logic v, input logic [31:0] s,
                         input logic [4:0] a, input logic [2:0] o);
    if (port == 0) begin
      req0_valid = v; req0_src = s; req0_amt = a; req0_op = o;
    end else begin
      req1_valid = v; req1_src = s; req1_amt = a; req1_op = o;
    end
  endtask

  // Single-port operation, response consumed immediately; entered and left at edge+1 in IDLE.
  task automatic run_op(input int port, input logic [31:0] s, input logic [4:0] a,
                        input logic [2:0] o, input logic [31:0] exp_d, input logic exp_e,
                        input string tag);
    set_req(port, 1'b1, s, a, o);
    #1;
    chk({tag, "_ready"}, (port == 0) ? req0_ready : req1_ready, 1);
    tick();
    set_req(port, 1'b0, s, a, o);
    chk({tag, "_exec_rspv"}, {rsp1_valid, rsp0_valid}, 0);
    tick();
    chk({tag, "_rspv"}, {rsp1_valid, rsp0_valid}, (port == 0) ? 2'b01 : 2'b10);
    chk({tag, "_data"}, rsp_data, exp_d);
    chk({tag, "_err"}, rsp_err, exp_e);
    if (port == 0) rsp0_ready = 1'b1; else rsp1_ready = 1'b1;
    tick();
    rsp0_ready = 1'b0; rsp1_ready = 1'b0;
    chk({tag, "_done_rspv"}, {rsp1_valid, rsp0_valid}, 0);
  endtask

  initial begin
    reset = 1'b1; flush = 1'b0;
    req0_valid = 0; req0_src = 0; req0_amt = 0; req0_op = 0;
    req1_valid = 0; req1_src = 0; req1_amt = 0; req1_op = 0;
    rsp0_ready = 0; rsp1_ready = 0;
    tick(); tick();
    chk("rst_req_ready", {req1_ready, req0_ready}, 0);
    chk("rst_rsp_valid", {rsp1_valid, rsp0_valid}, 0);
    chk("rst_rsp_data", rsp_data, 0);
    chk("rst_rsp_err", rsp_err, 0);
    req0_valid = 1'b1;
    #1;
    chk("rst_ready_in_reset", req0_ready, 0);
    req0_valid = 1'b0;
    reset = 1'b0;
    tick();

    run_op(0, 32'h0000_0001, 5'd31, 3'b100, 32'h8000_0000, 1'b0, "p0_sll31");
    run_op(1, 32'h8000_0000, 5'd4,  3'b001, 32'hF800_0000, 1'b0, "p1_sra4");
    run_op(1, 32'h8000_0000, 5'd4,  3'b010, 32'h0800_0000, 1'b0, "p1_srl4");
    run_op(1, 32'h7FFF_FFF0, 5'd0,  3'b001, 32'h7FFF_FFF0, 1'b0, "p1_sra0");

    // Alternation from a fresh reset with both ports valid and responses always taken.
    reset = 1'b1;
    tick();
    reset = 1'b0;
    rsp0_ready = 1'b1; rsp1_ready = 1'b1;
    set_req(0, 1'b1, 32'h0000_0001, 5'd1, 3'b100);
    set_req(1, 1'b1, 32'h0000_0008, 5'd1, 3'b010);
    for (int i = 0; i < 12; i++) begin
      #1;
      chk($sformatf("alt_r0_c%0d", i), req0_ready, (i % 3 == 0) && ((i / 3) % 2 == 0));
      chk($sformatf("alt_r1_c%0d", i), req1_ready, (i % 3 == 0) && ((i / 3) % 2 == 1));
      if (i % 3 == 2) begin
        chk($sformatf("alt_v_c%0d", i), {rsp1_valid, rsp0_valid}, ((i / 3) % 2 == 0) ? 2'b01 : 2'b10);
        chk($sformatf("alt_d_c%0d", i), rsp_data, ((i / 3) % 2 == 0) ? 32'h2 : 32'h4);
      end
      tick();
    end
    req0_valid = 1'b0; req1_valid = 1'b0;
    rsp0_ready = 1'b0; rsp1_ready = 1'b0;

    // Response back-pressure with a competing request waiting.
    set_req(0, 1'b1, 32'h1234_5678, 5'd4, 3'b100);
    #1;
    chk("bp_accept", req0_ready, 1);
    tick();
    req0_valid = 1'b0;
    set_req(1, 1'b1, 32'h0000_00F0, 5'd4, 3'b010);
    tick();
    for (int i = 0; i < 5; i++) begin
      #1;
      chk($sformatf("bp_v_%0d", i), rsp0_valid, 1);
      chk($sformatf("bp_d_%0d", i), rsp_data, 32'h2345_6780);
      chk($sformatf("bp_rdy_%0d", i), {req1_ready, req0_ready}, 0);
      tick();
    end
    rsp0_ready = 1'b1;
    #1;
    chk("bp_last_v", rsp0_valid, 1);
    tick();
    rsp0_ready = 1'b0;
    #1;
    chk("bp_idle_r1", req1_ready, 1);
    chk("bp_idle_v", rsp0_valid, 0);
    tick();
    req1_valid = 1'b0;
    tick();
    chk("bp_p1_v", rsp1_valid, 1);
    chk("bp_p1_d", rsp_data, 32'h0000_000F);
    rsp1_ready = 1'b1;
    tick();
    rsp1_ready = 1'b0;

    run_op(0, 32'hFFFF_FFFF, 5'd3, 3'b110, 32'h0, 1'b1, "err_110");
    run_op(0, 32'hFFFF_FFFF, 5'd3, 3'b000, 32'h0, 1'b1, "err_000");
    run_op(0, 32'h0000_0001, 5'd0, 3'b100, 32'h1, 1'b0, "err_recover");

    // Flush in EXEC, then flush in RESP with the response ready asserted.
    set_req(0, 1'b1, 32'h0000_0003, 5'd2, 3'b100);
    #1;
    chk("fl_accept0", req0_ready, 1);
    tick();
    set_req(1, 1'b1, 32'h8000_0000, 5'd31, 3'b001);
    flush = 1'b1;
    #1;
    chk("fl_exec_rdy", {req1_ready, req0_ready}, 0);
    tick();
    flush = 1'b0;
    #1;
    chk("fl_exec_rspv", {rsp1_valid, rsp0_valid}, 0);
    chk("fl_exec_grant", {req1_ready, req0_ready}, 2'b10);
    tick();
    tick();
    chk("fl_resp_v", rsp1_valid, 1);
    chk("fl_resp_d", rsp_data, 32'hFFFF_FFFF);
    flush = 1'b1; rsp1_ready = 1'b1;
    #1;
    chk("fl_resp_masked", {rsp1_valid, rsp0_valid}, 0);
    chk("fl_resp_rdy", {req1_ready, req0_ready}, 0);
    tick();
    flush = 1'b0; rsp1_ready = 1'b0;
    #1;
    chk("fl_resp_rspv", {rsp1_valid, rsp0_valid}, 0);
    chk("fl_resp_grant", {req1_ready, req0_ready}, 2'b01);

    // Reset in EXEC after port 0 won: pointer returns to port 0 anyway.
    tick();
    reset = 1'b1;
    #1;
    chk("rs_exec_rdy", {req1_ready, req0_ready}, 0);
    tick();
    reset = 1'b0;
    #1;
    chk("rs_grant", {req1_ready, req0_ready}, 2'b01);
    chk("rs_rspv", {rsp1_valid, rsp0_valid}, 0);
    chk("rs_data", rsp_data, 0);
    tick();
    req0_valid = 1'b0; req1_valid = 1'b0;
    tick();
    chk("rs_p0_v", {rsp1_valid, rsp0_valid}, 2'b01);
    chk("rs_p0_d", rsp_data, 32'h0000_000C);
    rsp0_ready = 1'b1;
    tick();
    rsp0_ready = 1'b0;
    chk("rs_p0_done", {rsp1_valid, rsp0_valid}, 0);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
